// File: rtl/cipher_bus_responder_if.sv
// cipher_bus_responder_if: request/result and round-unit signals of the cipher responder
interface cipher_bus_responder_if;
  logic         i_key_ready;
  logic [1:0]   i_key_mode;
  logic         i_enable;
  logic         i_ende;
  logic [127:0] i_data;
  logic         i_data_valid;
  logic         o_ready;
  logic [127:0] o_data;
  logic         o_data_valid;
  logic         o_abort;
  logic [127:0] o_rnd_state;
  logic [3:0]   o_rnd_idx;
  logic         o_rnd_dec;
  logic [127:0] i_rnd_result;
  modport slave (
    input  i_key_ready, i_key_mode, i_enable, i_ende, i_data, i_data_valid, i_rnd_result,
    output o_ready, o_data, o_data_valid, o_abort, o_rnd_state, o_rnd_idx, o_rnd_dec
  );
  modport master (
    output i_key_ready, i_key_mode, i_enable, i_ende, i_data, i_data_valid, i_rnd_result,
    input  o_ready, o_data, o_data_valid, o_abort, o_rnd_state, o_rnd_idx, o_rnd_dec
  );
endinterface

// File: rtl/cipher_bus_responder.sv
// cipher_bus_responder: sequences Nr+1 external round evaluations per accepted block
module cipher_bus_responder (
  input  logic                   clk,
  input  logic                   reset,
  cipher_bus_responder_if.slave  bus
);
  typedef enum logic {IDLE, ROUND} state_t;
  state_t       r_state, w_next;
  logic [127:0] r_sreg, r_data;
  logic [3:0]   r_idx, r_nr;
  logic         r_valid, r_abort, r_dec;
  logic         w_ready, w_accept, w_hold, w_done, w_abort;
  assign w_ready  = (r_state == IDLE) & bus.i_key_ready & (bus.i_key_mode != 2'b11) & ~reset;
  assign w_accept = w_ready & bus.i_enable & bus.i_data_valid;
  assign w_hold   = bus.i_enable & bus.i_key_ready;
  // an abort condition takes precedence over completing the final round
  assign w_abort  = (r_state == ROUND) & ~w_hold;
  assign w_done   = (r_state == ROUND) & w_hold & (r_idx == r_nr);
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? ROUND : (w_done | w_abort) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_nr    <= '0;
      r_valid <= 1'b0;
      r_abort <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_done;
      r_abort <= w_abort;
      if (w_accept) begin
        r_sreg <= bus.i_data;
        r_idx  <= '0;
        r_nr   <= (bus.i_key_mode == 2'b00) ? 4'd10 : (bus.i_key_mode == 2'b01) ? 4'd12 : 4'd14;
        r_dec  <= bus.i_ende;
      end else if (r_state == ROUND) begin
        if (w_done | w_abort) begin
          r_idx <= '0;
        end else begin
          r_sreg <= bus.i_rnd_result;
          r_idx  <= r_idx + 4'd1;
        end
        if (w_done) r_data <= bus.i_rnd_result;
      end
    end
  end
  assign bus.o_ready      = w_ready;
  assign bus.o_data       = r_data;
  assign bus.o_data_valid = r_valid;
  assign bus.o_abort      = r_abort;
  assign bus.o_rnd_state  = r_sreg;
  assign bus.o_rnd_idx    = r_idx;
  assign bus.o_rnd_dec    = r_dec;
endmodule

// File: tb/tb_cipher_bus_responder.sv
// tb_cipher_bus_responder: directed checks with an increment-by-one round unit
module tb_cipher_bus_responder;
  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total = 0;
  cipher_bus_responder_if bus ();
  cipher_bus_responder dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.i_rnd_result = bus.o_rnd_state + 128'd1;
  always #5 clk = ~clk;
  task automatic run_op(input logic [127:0] d, input logic [1:0] m, input logic e, input bit flip,
                        output int cyc, output logic [127:0] first, output bit rdy_seen, output bit dec_bad);
    bus.i_data = d; bus.i_key_mode = m; bus.i_ende = e; bus.i_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_data_valid = 1'b0;
    first = bus.o_data; cyc = -1; rdy_seen = bus.o_ready; dec_bad = (bus.o_rnd_dec !== e);
    if (flip) begin bus.i_ende = ~e; bus.i_key_mode = 2'b00; end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.o_data_valid) begin cyc = k; break; end
      if (bus.o_ready) rdy_seen = 1'b1;
      if (bus.o_rnd_dec !== e) dec_bad = 1'b1;
    end
  endtask
  task automatic wait_idx(input logic [3:0] n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.o_rnd_idx == n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1; bus.i_key_ready = 1'b1; bus.i_key_mode = 2'b00; bus.i_enable = 1'b1;
    bus.i_ende = 1'b0; bus.i_data = 128'h55; bus.i_data_valid = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++; if (bus.o_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.o_ready); else pass_cnt++;
    total++; if ({bus.o_data_valid, bus.o_abort, bus.o_rnd_dec, bus.o_rnd_idx} !== 7'd0) $display("FAIL reset_flags got=%h exp=0", {bus.o_data_valid, bus.o_abort, bus.o_rnd_dec, bus.o_rnd_idx}); else pass_cnt++;
    total++; if ({bus.o_data, bus.o_rnd_state} !== 256'd0) $display("FAIL reset_data got=%h/%h exp=0", bus.o_data, bus.o_rnd_state); else pass_cnt++;
    bus.i_data_valid = 1'b0; reset = 1'b0; #1;
    total++; if (bus.o_ready !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", bus.o_ready); else pass_cnt++;
  endtask
  task automatic test_aes128();
    int c; logic [127:0] f; bit r, db;
    run_op(128'h0, 2'b00, 1'b0, 1'b0, c, f, r, db);
    total++; if (c !== 11) $display("FAIL aes128_latency got=%0d exp=11", c); else pass_cnt++;
    total++; if (bus.o_data !== 128'h0B) $display("FAIL aes128_data got=%h exp=0b", bus.o_data); else pass_cnt++;
    total++; if (r !== 1'b0) $display("FAIL aes128_ready_busy got=%b exp=0", r); else pass_cnt++;
    total++; if (bus.o_ready !== 1'b1) $display("FAIL aes128_ready_valid got=%b exp=1", bus.o_ready); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (bus.o_data_valid !== 1'b0) $display("FAIL aes128_strobe_len got=%b exp=0", bus.o_data_valid); else pass_cnt++;
  endtask
  task automatic test_aes256_dec();
    int c; logic [127:0] f; bit r, db;
    run_op({128{1'b1}}, 2'b10, 1'b1, 1'b1, c, f, r, db);
    total++; if (c !== 15) $display("FAIL aes256_latency got=%0d exp=15", c); else pass_cnt++;
    total++; if (bus.o_data !== 128'h0E) $display("FAIL aes256_data got=%h exp=0e", bus.o_data); else pass_cnt++;
    total++; if (db !== 1'b0) $display("FAIL aes256_dec_held got=%b exp=0", db); else pass_cnt++;
    bus.i_ende = 1'b0; bus.i_key_mode = 2'b00;
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back();
    int c; logic [127:0] f; bit r, db;
    run_op(128'h10, 2'b01, 1'b0, 1'b0, c, f, r, db);
    total++; if (c !== 13 || bus.o_data !== 128'h1D) $display("FAIL b2b_first got=%0d/%h exp=13/1d", c, bus.o_data); else pass_cnt++;
    run_op(128'h20, 2'b01, 1'b0, 1'b0, c, f, r, db);
    total++; if (f !== 128'h1D) $display("FAIL b2b_hold got=%h exp=1d", f); else pass_cnt++;
    total++; if (c !== 13 || bus.o_data !== 128'h2D) $display("FAIL b2b_second got=%0d/%h exp=13/2d", c, bus.o_data); else pass_cnt++;
    bus.i_key_mode = 2'b00;
    @(posedge clk); #1;
  endtask
  task automatic test_abort();
    bit ok;
    bus.i_data = 128'h5; bus.i_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_data_valid = 1'b0;
    wait_idx(4'd5, ok);
    total++; if (!ok) $display("FAIL abort_reach_round got=%0d exp=5", bus.o_rnd_idx); else pass_cnt++;
    bus.i_enable = 1'b0;
    @(posedge clk); #1;
    total++; if ({bus.o_abort, bus.o_data_valid} !== 2'b10) $display("FAIL abort_strobe got=%b exp=10", {bus.o_abort, bus.o_data_valid}); else pass_cnt++;
    total++; if (bus.o_data !== 128'h2D) $display("FAIL abort_data_kept got=%h exp=2d", bus.o_data); else pass_cnt++;
    total++; if (bus.o_ready !== 1'b1 || bus.o_rnd_idx !== 4'd0) $display("FAIL abort_idle got=%b/%0d exp=1/0", bus.o_ready, bus.o_rnd_idx); else pass_cnt++;
    bus.i_enable = 1'b1;
    @(posedge clk); #1;
    total++; if ({bus.o_abort, bus.o_data_valid} !== 2'b00) $display("FAIL abort_one_cycle got=%b exp=00", {bus.o_abort, bus.o_data_valid}); else pass_cnt++;
    bus.i_data = 128'h7; bus.i_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_data_valid = 1'b0;
    wait_idx(4'd2, ok);
    bus.i_key_ready = 1'b0;
    @(posedge clk); #1;
    total++; if ({bus.o_abort, bus.o_data_valid, bus.o_ready} !== 3'b100) $display("FAIL keyloss_abort got=%b exp=100", {bus.o_abort, bus.o_data_valid, bus.o_ready}); else pass_cnt++;
    bus.i_key_ready = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid_op();
    bit ok;
    bus.i_data = 128'h40; bus.i_data_valid = 1'b1; bus.i_ende = 1'b1;
    @(posedge clk); #1;
    bus.i_data_valid = 1'b0;
    wait_idx(4'd3, ok);
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if ({bus.o_data, bus.o_rnd_state} !== 256'd0) $display("FAIL midreset_data got=%h/%h exp=0", bus.o_data, bus.o_rnd_state); else pass_cnt++;
    total++; if ({bus.o_data_valid, bus.o_abort, bus.o_rnd_dec, bus.o_rnd_idx, bus.o_ready} !== 8'd0) $display("FAIL midreset_flags got=%h exp=0", {bus.o_data_valid, bus.o_abort, bus.o_rnd_dec, bus.o_rnd_idx, bus.o_ready}); else pass_cnt++;
    reset = 1'b0; bus.i_ende = 1'b0;
    @(posedge clk); #1;
    total++; if ({bus.o_data_valid, bus.o_abort, bus.o_ready} !== 3'b001) $display("FAIL midreset_after got=%b exp=001", {bus.o_data_valid, bus.o_abort, bus.o_ready}); else pass_cnt++;
  endtask
  task automatic test_ignored();
    bus.i_enable = 1'b0; bus.i_data = 128'h99; bus.i_data_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.o_rnd_state !== 128'd0 || bus.o_ready !== 1'b1) $display("FAIL disabled_ignore got=%h/%b exp=0/1", bus.o_rnd_state, bus.o_ready); else pass_cnt++;
    bus.i_enable = 1'b1; bus.i_key_mode = 2'b11; #1;
    total++; if (bus.o_ready !== 1'b0) $display("FAIL mode11_ready got=%b exp=0", bus.o_ready); else pass_cnt++;
    repeat (3) @(posedge clk); #1;
    total++; if ({bus.o_rnd_state, bus.o_rnd_idx, bus.o_data_valid, bus.o_abort, bus.o_ready} !== 135'd0) $display("FAIL mode11_idle got=%h/%0d/%b%b%b exp=0", bus.o_rnd_state, bus.o_rnd_idx, bus.o_data_valid, bus.o_abort, bus.o_ready); else pass_cnt++;
    bus.i_data_valid = 1'b0; bus.i_key_mode = 2'b00;
  endtask
  initial begin
    test_reset();
    test_aes128();
    test_aes256_dec();
    test_back_to_back();
    test_abort();
    test_reset_mid_op();
    test_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
